// File: rtl/mux41_rr_sched_pkg.sv
// Shared types and helpers for the mux41 round-robin scheduler.
// The rotating-priority pick lives here so the arbiter sub-module and any
// future users agree on exactly one search order.
package mux41_sched_pkg;

  // The scheduler fronts a 4:1 selector, so requester count and select width
  // are tied together and fixed.
  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Result of one arbitration: winning index plus whether anyone asked.
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Search last+1, last+2, last+3, last (mod 4); first set request wins.
  // The 2-bit addition wraps naturally, which gives the modulo for free.
  function automatic pick_t rr_pick(input logic [NREQ-1:0]  req,
                                    input logic [SEL_W-1:0] last);
    pick_t            p;
    logic [SEL_W-1:0] cand;
    p = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last + SEL_W'(k);
      if (!p.found && req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

  // One-hot decode of a selector index into a grant vector.
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux41_rr_sched_if.sv
// Requester-side bundle of the mux41 scheduler: enable, requests and dwell
// flow into the scheduler; select, grant and status flow back out.
interface mux41_rr_sched_if #(
  parameter int DWELL_W = 8
);
  import mux41_sched_pkg::*;

  logic                en;
  logic [NREQ-1:0]     req;
  logic [DWELL_W-1:0]  dwell;
  logic [SEL_W-1:0]    sel;
  logic [NREQ-1:0]     grant;
  logic                valid;
  logic                done;

  // Requester / top-level side: issues requests, observes grants.
  modport master (
    output en, req, dwell,
    input  sel, grant, valid, done
  );

  // Scheduler side: consumes requests, owns the select and grant.
  modport slave (
    input  en, req, dwell,
    output sel, grant, valid, done
  );

endinterface

// File: rtl/mux41_rr_sched_arbiter.sv
// Purely combinational 4-way rotating-priority picker. Given the request
// vector and the index granted last, returns the next winner and whether
// any request was present at all.
module rr_arbiter4
  import mux41_sched_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  pick_t pick;

  // Rotate priority so the requester after the last grantee is tried first.
  always_comb begin
    // NOTE: every output of an always_comb gets a default before any branch
    // so no path leaves it unassigned and a latch cannot be inferred.
    pick  = '0;
    pick  = rr_pick(req, last);
    idx   = pick.idx;
    found = pick.found;
  end

endmodule

// File: rtl/mux41_rr_sched.sv
// Round-robin scheduler sharing the mux41 4:1 2-bit selector between four
// requesters. A winner holds the selector for a programmable dwell time,
// releases early if it drops its request, and hands over back-to-back to the
// next requester without an idle bubble. All outputs are registered.
module mux41_rr_sched #(
  parameter int NREQ    = 4,   // fixed to match the 4:1 selector
  parameter int DWELL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mux41_rr_sched_if.slave        bus
);

  import mux41_sched_pkg::*;

  state_t             state;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   last_q;
  logic [NREQ-1:0]    grant_q;
  logic               valid_q;
  logic               done_q;
  logic [DWELL_W-1:0] cnt;

  logic [SEL_W-1:0]   arb_last;
  logic [SEL_W-1:0]   arb_idx;
  logic               arb_found;
  logic [DWELL_W-1:0] dwell_eff;
  logic               hold_end;
  logic               regrant;

  // While holding, the grant that is about to end becomes "last" in the same
  // edge, so re-arbitration must rotate from the current select rather than
  // the stale last_q register.
  assign arb_last = (state == HOLD) ? sel_q : last_q;

  // A dwell of zero would underflow the counter; treat it as one cycle.
  assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

  // A grant ends when its count runs out or its owner lets go early.
  assign hold_end = (cnt == DWELL_W'(1)) || !bus.req[sel_q];

  // A new grant may only start while enabled and someone is asking.
  assign regrant = bus.en && arb_found;

  rr_arbiter4 u_arb (
    .req   (bus.req),
    .last  (arb_last),
    .idx   (arb_idx),
    .found (arb_found)
  );

  // Scheduler FSM: issues grants, counts dwell, and produces all outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      last_q  <= '1;     // so the first search begins at requester 0
      grant_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // this block sees the pre-edge values, independent of statement order.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (regrant) begin
            state   <= HOLD;
            sel_q   <= arb_idx;
            grant_q <= onehot(arb_idx);
            valid_q <= 1'b1;
            cnt     <= dwell_eff;
          end
        end

        HOLD: begin
          if (hold_end) begin
            last_q <= sel_q;
            done_q <= 1'b1;
            if (regrant) begin
              // Back-to-back handover: valid stays high, no idle cycle.
              sel_q   <= arb_idx;
              grant_q <= onehot(arb_idx);
              cnt     <= dwell_eff;
            end else begin
              // Select is left pointing at the last grantee.
              state   <= IDLE;
              grant_q <= '0;
              valid_q <= 1'b0;
              cnt     <= '0;
            end
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.valid = valid_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_mux41_rr_sched.sv
// Scoreboard bench for mux41_rr_sched: each directed vector drives inputs
// before an edge and queues the hand-computed outputs expected after it; an
// independent monitor pops and compares after every rising edge.
module tb_mux41_rr_sched;
  import mux41_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mux41_rr_sched_if #(.DWELL_W(8)) bus ();

  mux41_rr_sched #(.NREQ(4), .DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         tag;
    logic [7:0] outs;   // {sel, grant, valid, done}
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tag   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got sel=%0d grant=%b valid=%b done=%b, expected sel=%0d grant=%b valid=%b done=%b",
               name, act[7:6], act[5:2], act[1], act[0], exp[7:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [7:0] pack_outs();
    return {bus.sel, bus.grant, bus.valid, bus.done};
  endfunction

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic step(input logic [3:0] r, input logic e, input logic [7:0] d,
                      input logic [1:0] s, input logic [3:0] g, input logic v, input logic dn);
    exp_t x;
    @(negedge clk);
    bus.req   = r;
    bus.en    = e;
    bus.dwell = d;
    tag++;
    x.tag  = tag;
    x.outs = {s, g, v, dn};
    sb.push_back(x);
  endtask

  // Wait, with a bound, for the monitor to consume every queued vector.
  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compare the registered outputs just after each rising edge.
  initial begin
    exp_t m;
    forever begin
      @(posedge clk);
      #1;
      if (rst && sb.size() > 0) begin
        m = sb.pop_front();
        check($sformatf("vec%0d", m.tag), pack_outs(), m.outs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req   = '0;
    bus.en    = 1'b1;
    bus.dwell = '0;

    // Reset state and idle after release with no requests.
    #3;
    check("reset", pack_outs(), {2'd0, 4'b0000, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step(4'b0000, 1, 8'd0, 2'd0, 4'b0000, 0, 0);

    // Single persistent requester, dwell 3: re-granted with a done per period.
    step(4'b0001, 1, 8'd3, 2'd0, 4'b0001, 1, 0);
    step(4'b0001, 1, 8'd3, 2'd0, 4'b0001, 1, 0);
    step(4'b0001, 1, 8'd3, 2'd0, 4'b0001, 1, 0);
    step(4'b0001, 1, 8'd3, 2'd0, 4'b0001, 1, 1);
    step(4'b0001, 1, 8'd3, 2'd0, 4'b0001, 1, 0);
    step(4'b0001, 1, 8'd3, 2'd0, 4'b0001, 1, 0);
    step(4'b0001, 1, 8'd3, 2'd0, 4'b0001, 1, 1);
    step(4'b0000, 1, 8'd3, 2'd0, 4'b0000, 0, 1);
    step(4'b0000, 1, 8'd3, 2'd0, 4'b0000, 0, 0);

    // Round-robin with all requesting, dwell 2 (last grantee was 0).
    step(4'b1111, 1, 8'd2, 2'd1, 4'b0010, 1, 0);
    step(4'b1111, 1, 8'd2, 2'd1, 4'b0010, 1, 0);
    step(4'b1111, 1, 8'd2, 2'd2, 4'b0100, 1, 1);
    step(4'b1111, 1, 8'd2, 2'd2, 4'b0100, 1, 0);
    step(4'b1111, 1, 8'd2, 2'd3, 4'b1000, 1, 1);
    step(4'b1111, 1, 8'd2, 2'd3, 4'b1000, 1, 0);
    step(4'b1111, 1, 8'd2, 2'd0, 4'b0001, 1, 1);
    step(4'b1111, 1, 8'd2, 2'd0, 4'b0001, 1, 0);
    step(4'b1111, 1, 8'd2, 2'd1, 4'b0010, 1, 1);
    step(4'b0000, 1, 8'd2, 2'd1, 4'b0000, 0, 1);
    step(4'b0000, 1, 8'd2, 2'd1, 4'b0000, 0, 0);

    // Early release of requester 2 after four granted cycles, then 0 next.
    step(4'b0100, 1, 8'd10, 2'd2, 4'b0100, 1, 0);
    step(4'b0100, 1, 8'd10, 2'd2, 4'b0100, 1, 0);
    step(4'b0100, 1, 8'd10, 2'd2, 4'b0100, 1, 0);
    step(4'b0100, 1, 8'd10, 2'd2, 4'b0100, 1, 0);
    step(4'b0000, 1, 8'd10, 2'd2, 4'b0000, 0, 1);
    step(4'b0101, 1, 8'd1,  2'd0, 4'b0001, 1, 0);
    // Dwell 0 behaves as a one-cycle grant.
    step(4'b0101, 1, 8'd0,  2'd2, 4'b0100, 1, 1);
    step(4'b0101, 1, 8'd0,  2'd0, 4'b0001, 1, 1);
    step(4'b0000, 1, 8'd0,  2'd0, 4'b0000, 0, 1);
    step(4'b0000, 1, 8'd0,  2'd0, 4'b0000, 0, 0);

    // en dropped mid-hold, dwell 5 then changed to 1: grant still runs 5.
    step(4'b1111, 1, 8'd5, 2'd1, 4'b0010, 1, 0);
    step(4'b1111, 0, 8'd1, 2'd1, 4'b0010, 1, 0);
    step(4'b1111, 0, 8'd1, 2'd1, 4'b0010, 1, 0);
    step(4'b1111, 0, 8'd1, 2'd1, 4'b0010, 1, 0);
    step(4'b1111, 0, 8'd1, 2'd1, 4'b0010, 1, 0);
    step(4'b1111, 0, 8'd1, 2'd1, 4'b0000, 0, 1);
    step(4'b1111, 0, 8'd1, 2'd1, 4'b0000, 0, 0);
    step(4'b1111, 0, 8'd1, 2'd1, 4'b0000, 0, 0);

    // Reset in the middle of a grant to requester 2.
    step(4'b0100, 1, 8'd8, 2'd2, 4'b0100, 1, 0);
    step(4'b0100, 1, 8'd8, 2'd2, 4'b0100, 1, 0);
    drain();
    rst = 1'b0;
    #1;
    check("midhold reset", pack_outs(), {2'd0, 4'b0000, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    check("reset held", pack_outs(), {2'd0, 4'b0000, 1'b0, 1'b0});
    bus.req = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    step(4'b0000, 1, 8'd2, 2'd0, 4'b0000, 0, 0);
    step(4'b1111, 1, 8'd2, 2'd0, 4'b0001, 1, 0);
    step(4'b1111, 1, 8'd2, 2'd0, 4'b0001, 1, 0);
    step(4'b1111, 1, 8'd2, 2'd1, 4'b0010, 1, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
